// File: rtl/regfile_writeback.sv
// 32 x 32-bit MIPS register file with a write-back formatter that merges and
// extends sub-word and unaligned loads (LB/LBU/LH/LHU/LWL/LWR) before commit.
module regfile_writeback #(
  parameter int          BYPASS      = 0,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        write_enable,
  input  logic [4:0]  write_reg_rd,
  input  logic [31:0] write_data,
  input  logic [2:0]  load_type,
  input  logic [1:0]  byte_offset,
  input  logic [4:0]  read_reg_a,
  input  logic [4:0]  read_reg_b,
  output logic [31:0] read_data_a,
  output logic [31:0] read_data_b,
  output logic [31:0] register_v0
);

  typedef enum logic [2:0] {
    LT_WORD = 3'd0,
    LT_LB   = 3'd1,
    LT_LBU  = 3'd2,
    LT_LH   = 3'd3,
    LT_LHU  = 3'd4,
    LT_LWL  = 3'd5,
    LT_LWR  = 3'd6,
    LT_RSVD = 3'd7
  } load_type_e;

  localparam bit BYPASS_EN = (BYPASS != 0);

  logic [31:0] regs_q [32];
  logic [31:0] merge_d;
  logic [31:0] rd_old;
  logic [7:0]  w_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        wr_commit;
  load_type_e  lt;

  // Big-endian lanes: lane 0 is the byte at address offset 0, i.e. W[31:24].
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_byte[gi] = write_data[31-8*gi -: 8];
    end
  endgenerate

  assign lt        = load_type_e'(load_type);
  assign wr_commit = write_enable && (write_reg_rd != 5'd0);
  assign rd_old    = regs_q[write_reg_rd];
  assign sel_byte  = w_byte[byte_offset];
  assign sel_half  = byte_offset[1] ? write_data[15:0] : write_data[31:16];

  always_comb begin
    merge_d = write_data;
    case (lt)
      LT_LB:  merge_d = {{24{sel_byte[7]}}, sel_byte};
      LT_LBU: merge_d = {24'h0, sel_byte};
      LT_LH:  merge_d = {{16{sel_half[15]}}, sel_half};
      LT_LHU: merge_d = {16'h0, sel_half};
      LT_LWL: begin
        case (byte_offset)
          2'd0:    merge_d = write_data;
          2'd1:    merge_d = {write_data[23:0], rd_old[7:0]};
          2'd2:    merge_d = {write_data[15:0], rd_old[15:0]};
          default: merge_d = {write_data[7:0],  rd_old[23:0]};
        endcase
      end
      LT_LWR: begin
        case (byte_offset)
          2'd3:    merge_d = write_data;
          2'd2:    merge_d = {rd_old[31:24], write_data[31:8]};
          2'd1:    merge_d = {rd_old[31:16], write_data[31:16]};
          default: merge_d = {rd_old[31:8],  write_data[31:24]};
        endcase
      end
      default: merge_d = write_data;
    endcase
  end

  // Entry 0 is reset to zero and never written, so it reads as a constant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q[0] <= 32'h0;
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
    end else if (wr_commit) begin
      regs_q[write_reg_rd] <= merge_d;
    end
  end

  logic bypass_a;
  logic bypass_b;

  // Forwarding is suppressed during reset so the ports reflect the cleared array.
  assign bypass_a = BYPASS_EN && reset_n && wr_commit && (read_reg_a == write_reg_rd);
  assign bypass_b = BYPASS_EN && reset_n && wr_commit && (read_reg_b == write_reg_rd);

  assign read_data_a = (read_reg_a == 5'd0) ? 32'h0 :
                       bypass_a             ? merge_d : regs_q[read_reg_a];
  assign read_data_b = (read_reg_b == 5'd0) ? 32'h0 :
                       bypass_b             ? merge_d : regs_q[read_reg_b];
  assign register_v0 = regs_q[2];

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- 32 x 32-bit MIPS general-purpose register file with an integrated write-back formatter.
- Consumes the destination register index chosen by the destination register selector (write_reg_rd), plus the write-back word (ALU result or memory read word) and the load type from control.
- Sub-word and unaligned loads (LB/LBU/LH/LHU/LWL/LWR) are merged and extended before commit.
- Provides the rs/rt read ports to the datapath and exposes $v0 for the testbench.

Parameters:
- BYPASS, 0, 1 = read ports return the value being written this cycle when addresses match; 0 = read ports return the stored value only.
- RESET_VALUE, 32'h0, value loaded into every register on reset.

Ports:
- clk  input  1  system clock; all register writes occur on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- write_enable  input  1  commit the write-back value at the next rising edge
- write_reg_rd  input  5  destination register index from the destination register selector
- write_data  input  32  ALU result or memory read word; byte at address offset 0 is in [31:24]
- load_type  input  3  0 WORD/ALU, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 reserved
- byte_offset  input  2  effective address [1:0] of the load
- read_reg_a  input  5  rs index
- read_reg_b  input  5  rt index
- read_data_a  output  32  contents of rs
- read_data_b  output  32  contents of rt
- register_v0  output  32  contents of register 2

Behaviour:
- Reset:
  - reset_n low asynchronously sets all 32 registers to RESET_VALUE, except $0, which stays 0.
  - All outputs follow from the array immediately.
  - Reset asserted while write_enable is high: the write is discarded; reset wins.
- Reads:
  - read_data_a/b and register_v0 are combinational from the array.
  - Index 0 always returns 0.
- Merge function: merged value M is formed from write_data (W) and the current contents of write_reg_rd (R), using R as it stands before this edge. Big-endian byte lanes; B0 = W[31:24] … B3 = W[7:0].
  - Type 0 (WORD/ALU) and type 7: M = W.
  - LB: M = sign-extend(B[byte_offset]).
  - LBU: M = zero-extend(B[byte_offset]).
  - LH: byte_offset[1] = 0 selects W[31:16], = 1 selects W[15:0]; sign-extended. byte_offset[0] is ignored.
  - LHU: same halfword select as LH, zero-extended.
  - LWL, by byte_offset:
    - 0: M = W
    - 1: M = {W[23:0], R[7:0]}
    - 2: M = {W[15:0], R[15:0]}
    - 3: M = {W[7:0], R[23:0]}
  - LWR, by byte_offset:
    - 3: M = W
    - 2: M = {R[31:24], W[31:8]}
    - 1: M = {R[31:16], W[31:16]}
    - 0: M = {R[31:8], W[31:24]}
- Write:
  - At the rising clk edge with write_enable = 1 and write_reg_rd != 0, reg[write_reg_rd] <= M.
  - write_reg_rd = 0 means no state change.
  - write_enable = 0 means no state change regardless of the other inputs.
- Latency: a written value is visible on the read ports one cycle after the edge.
  - With BYPASS = 1 it is visible in the same cycle when read index == write_reg_rd != 0 and write_enable = 1, and the port shows M, not W.
- Simultaneous read/write of the same index with BYPASS = 0: the read returns the old value until the edge.
- Reserved load_type 7 behaves exactly as 0; no error flag.

Test Plan:
1. Reset: pulse reset_n low mid-cycle with write_enable = 1, write_reg_rd = 5, write_data = 32'hDEADBEEF -> all read ports and register_v0 read 0 immediately; reg5 = 0 after release.
2. $0 protection: write_enable = 1, write_reg_rd = 0, write_data = 32'hFFFFFFFF -> read_reg_a = 0 returns 0; write 32'h12345678 to reg2 -> register_v0 = 32'h12345678 the next cycle.
3. Sub-word loads with write_data = 32'h80F17F22, write_reg_rd = 8:
   - LB offset 0 -> 32'hFFFFFF80.
   - LBU offset 0 -> 32'h00000080.
   - LB offset 2 -> 32'h0000007F.
   - LH offset 2 -> 32'h00007F22.
   - LHU offset 0 -> 32'h000080F1.
4. Unaligned loads with reg9 = 32'hAABBCCDD and write_data = 32'h11223344:
   - LWL offset 1 -> 32'h223344DD.
   - LWL offset 0 -> 32'h11223344.
   - LWR offset 1 -> 32'hAABB1122.
   - LWR offset 3 -> 32'h11223344.
5. Back-to-back LWL offset 2 then LWR offset 1 to reg10 (initially 0), both with write_data = 32'h11223344:
   - After the LWL edge, reg10 = 32'h33440000.
   - The LWR then uses that value as R -> final reg10 = 32'h33441122.
6. Bypass: BYPASS = 1, write reg3 with 32'hCAFEF00D while read_reg_a = 3 -> read_data_a = 32'hCAFEF00D in the same cycle. With BYPASS = 0 it shows the old value until the edge. write_enable = 0 with the same inputs -> no change.
